regfile_2r1w_latched: RTL and testbench
=======================================

// Module: regfile_2r1w_latched
// PURPOSE
//  32 x DATA_W register file: storage feeding the 32:1 operand-select muxes of the multicycle datapath.
//  Two read ports and one write port.
//  Selected operands are captured into A/B operand latches, which drive the ALU-source stage.
//  Register 0 reads as zero. Write-to-read bypass lets a same-cycle writeback reach a latched read.
// PARAMETERS
//  DATA_W     32   width of each register and of A/B outputs
//  ZERO_REG0  1    1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary storage
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  rd_req     in   1       pulse: capture operands addressed by rs1/rs2 into A/B
//  rs1        in   5       read address, port A
//  rs2        in   5       read address, port B
//  we         in   1       write enable
//  wa         in   5       write address
//  wd         in   DATA_W  write data
//  a_out      out  DATA_W  latched operand A
//  b_out      out  DATA_W  latched operand B
//  rd_valid   out  1       1 for exactly one cycle after rd_req was sampled
//  a_hazard   out  1       latched: operand A was bypassed from wd (debug/perf)
//  b_hazard   out  1       latched: operand B was bypassed from wd
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all 32 registers clear to 0
//   - a_out, b_out, rd_valid, a_hazard, b_hazard clear to 0
//   - takes effect immediately mid-operation; a write or read in that cycle is discarded
//  Write:
//   - on posedge with we=1, reg[wa] <= wd
//   - if ZERO_REG0=1 and wa=0, the write is dropped and reg[0] stays 0
//  Read/latch:
//   - on posedge with rd_req=1, a_out <= sel(rs1) and b_out <= sel(rs2); rd_valid <= 1
//   - sel(r) = 0 when ZERO_REG0=1 and r=0
//   - sel(r) = wd when we=1 and wa=r (and r is writable); the matching hazard flag is set to 1
//   - sel(r) = reg[r] otherwise; the matching hazard flag is cleared to 0
//   - Latency: 1 cycle from rd_req to a_out/b_out/rd_valid.
//  Hold:
//   - with rd_req=0: a_out, b_out and the hazard flags hold their last values; rd_valid <= 0
//   - a later write to a register already latched does NOT update a_out/b_out
//  Simultaneous events:
//   - back-to-back rd_req: each cycle re-latches; rd_valid stays 1 continuously
//   - rs1 = rs2 = wa with we=1: both A and B get wd; both hazard flags are set
//   - we=1, wa=0, ZERO_REG0=1, rs1=0: A=0, a_hazard=0
//  Address width: exactly 5 bits, so there is no out-of-range case; no default path is needed.
//  Combinational paths: none from inputs to outputs; all outputs are registered.
// TESTING
//  1) Reset: hold rst_n=0 mid-write (we=1, wa=5, wd=32'hDEAD_BEEF), release, then rd_req with rs1=5
//     -> a_out=0 and rd_valid=1 one cycle later.
//  2) Write/read: write reg[3]=32'h1234_5678 and reg[31]=32'hFFFF_FFFF; next cycle rd_req rs1=3, rs2=31
//     -> a_out=32'h1234_5678, b_out=32'hFFFF_FFFF, hazards=0.
//  3) Bypass: same cycle we=1, wa=7, wd=32'hA5A5_A5A5, rd_req, rs1=7, rs2=7
//     -> a_out=b_out=32'hA5A5_A5A5, a_hazard=b_hazard=1.
//  4) Zero reg: write wa=0, wd=32'h0000_0042; rd_req rs1=0, including the same-cycle case
//     -> a_out=0, a_hazard=0. With ZERO_REG0=0 -> 32'h0000_0042.
//  5) Hold: latch rs1=9 (value 32'h11); write reg[9]=32'h22 with rd_req=0
//     -> a_out stays 32'h11, rd_valid=0; the next rd_req yields 32'h22.
//  6) Sweep: write reg[i]=i*32'h0101_0101 for i=1..31, then read all pairs (i, 31-i)
//     -> each output matches the model; no aliasing between addresses.

Source files
------------

// File: rtl/regfile_2r1w_latched.sv
// 32 x DATA_W register file with two latched read ports and one write port.
// Reads capture into A/B operand registers; a same-cycle write is bypassed into the capture.
module regfile_2r1w_latched #(
   parameter int DATA_W    = 32,
   parameter bit ZERO_REG0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              rd_valid,
   output logic              a_hazard,
   output logic              b_hazard
);

   // Handshake: rd_req is a one-cycle request with no backpressure; rd_valid is
   // its registered one-cycle response, asserted the cycle after each sampled rd_req.

   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];

   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              rd_valid_q, rd_valid_d;
   logic              a_hazard_q, a_hazard_d;
   logic              b_hazard_q, b_hazard_d;

   logic              wr_ok;
   logic [DATA_W-1:0] a_sel, b_sel;
   logic              a_byp, b_byp;

   assign wr_ok = we && !(ZERO_REG0 && (wa == 5'd0));

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) begin
         regs_d[wa] = wd;
      end
   end

   // Operand select: hard zero first, then bypass from the write port, then storage.
   always_comb begin
      a_sel = regs_q[rs1];
      a_byp = 1'b0;
      if (ZERO_REG0 && (rs1 == 5'd0)) begin
         a_sel = '0;
      end else if (we && (wa == rs1)) begin
         a_sel = wd;
         a_byp = 1'b1;
      end
   end

   always_comb begin
      b_sel = regs_q[rs2];
      b_byp = 1'b0;
      if (ZERO_REG0 && (rs2 == 5'd0)) begin
         b_sel = '0;
      end else if (we && (wa == rs2)) begin
         b_sel = wd;
         b_byp = 1'b1;
      end
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      a_hazard_d = a_hazard_q;
      b_hazard_d = b_hazard_q;
      rd_valid_d = rd_req;
      if (rd_req) begin
         a_d        = a_sel;
         b_d        = b_sel;
         a_hazard_d = a_byp;
         b_hazard_d = b_byp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         a_q        <= '0;
         b_q        <= '0;
         rd_valid_q <= 1'b0;
         a_hazard_q <= 1'b0;
         b_hazard_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rd_valid_q <= rd_valid_d;
         a_hazard_q <= a_hazard_d;
         b_hazard_q <= b_hazard_d;
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign rd_valid = rd_valid_q;
   assign a_hazard = a_hazard_q;
   assign b_hazard = b_hazard_q;

endmodule

// File: tb/tb_regfile_2r1w_latched.sv
// Bench for regfile_2r1w_latched: two instances (register 0 hardwired / ordinary)
// driven in lockstep and compared against an array-based model of the read/write rules.
module tb_regfile_2r1w_latched;

   localparam int W  = 32;
   localparam int PW = 2 * W + 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         rd_req, we;
   logic [4:0]   rs1, rs2, wa;
   logic [W-1:0] wd;

   logic [W-1:0] a_z, b_z, a_n, b_n;
   logic         v_z, ah_z, bh_z, v_n, ah_n, bh_n;

   regfile_2r1w_latched #(.DATA_W(W), .ZERO_REG0(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rs1(rs1), .rs2(rs2),
      .we(we), .wa(wa), .wd(wd), .a_out(a_z), .b_out(b_z),
      .rd_valid(v_z), .a_hazard(ah_z), .b_hazard(bh_z)
   );

   regfile_2r1w_latched #(.DATA_W(W), .ZERO_REG0(1'b0)) dut_nz (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rs1(rs1), .rs2(rs2),
      .we(we), .wa(wa), .wd(wd), .a_out(a_n), .b_out(b_n),
      .rd_valid(v_n), .a_hazard(ah_n), .b_hazard(bh_n)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [W-1:0]  mem_z [32];
   logic [W-1:0]  mem_n [32];
   logic [PW-1:0] last_z, last_n;
   logic [PW-1:0] exp_z_q [$];
   logic [PW-1:0] exp_n_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all(input string who, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      check({who, ".rd_valid"}, W'(obs[PW-1]), W'(exp[PW-1]));
      check({who, ".a_hazard"}, W'(obs[PW-2]), W'(exp[PW-2]));
      check({who, ".b_hazard"}, W'(obs[PW-3]), W'(exp[PW-3]));
      check({who, ".a_out"}, obs[2*W-1:W], exp[2*W-1:W]);
      check({who, ".b_out"}, obs[W-1:0], exp[W-1:0]);
   endtask

   // Value a read of register r would see this cycle, with the bypass flag on top.
   function automatic logic [W:0] sel_ref(input bit zero, input logic [4:0] r);
      logic [W-1:0] stored;
      stored = zero ? mem_z[r] : mem_n[r];
      if (zero && r == 5'd0) return {1'b0, {W{1'b0}}};
      if (we && wa == r) return {1'b1, wd};
      return {1'b0, stored};
   endfunction

   function automatic logic [PW-1:0] predict(input bit zero, input logic [PW-1:0] last);
      logic [W:0] sa, sb;
      if (!rd_req) return {1'b0, last[PW-2:0]};
      sa = sel_ref(zero, rs1);
      sb = sel_ref(zero, rs2);
      return {1'b1, sa[W], sb[W], sa[W-1:0], sb[W-1:0]};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) begin
         mem_z[i] = '0;
         mem_n[i] = '0;
      end
      last_z = '0;
      last_n = '0;
      exp_z_q.delete();
      exp_n_q.delete();
   endfunction

   task automatic compare_now();
      logic [PW-1:0] ez, en;
      ez = exp_z_q.pop_front();
      en = exp_n_q.pop_front();
      cmp_all("z", {v_z, ah_z, bh_z, a_z, b_z}, ez);
      cmp_all("nz", {v_n, ah_n, bh_n, a_n, b_n}, en);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit rq, input logic [4:0] a1, input logic [4:0] a2,
                        input bit w, input logic [4:0] waddr, input logic [W-1:0] data);
      rd_req = rq; rs1 = a1; rs2 = a2; we = w; wa = waddr; wd = data;
      last_z = predict(1'b1, last_z);
      last_n = predict(1'b0, last_n);
      exp_z_q.push_back(last_z);
      exp_n_q.push_back(last_n);
      if (w) begin
         if (waddr != 5'd0) mem_z[waddr] = data;
         mem_n[waddr] = data;
      end
      @(posedge clk);
      #1;
      compare_now();
   endtask

   // Asserts reset mid-cycle with whatever inputs are currently driven.
   task automatic reset_mid();
      rst_n = 1'b0;
      #1;
      model_clear();
      cmp_all("z_rst", {v_z, ah_z, bh_z, a_z, b_z}, '0);
      cmp_all("nz_rst", {v_n, ah_n, bh_n, a_n, b_n}, '0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rd_req = 1'b0; rs1 = '0; rs2 = '0; we = 1'b0; wa = '0; wd = '0;
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      cmp_all("z_por", {v_z, ah_z, bh_z, a_z, b_z}, '0);
      cmp_all("nz_por", {v_n, ah_n, bh_n, a_n, b_n}, '0);
      rst_n = 1'b1;

      // Reset mid-write must clear storage and drop the in-flight write.
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h0000_0055);
      drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
      rd_req = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
      reset_mid();
      drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
      check("t1_a", a_z, 32'h0);
      check("t1_valid", W'(v_z), 32'h1);

      // Plain write then read.
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h1234_5678);
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'hFFFF_FFFF);
      drive(1'b1, 5'd3, 5'd31, 1'b0, 5'd0, 32'h0);
      check("t2_a", a_z, 32'h1234_5678);
      check("t2_b", b_z, 32'hFFFF_FFFF);

      // Same-cycle bypass on both ports.
      drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
      check("t3_ah", W'(ah_z), 32'h1);
      check("t3_b", b_z, 32'hA5A5_A5A5);

      // Register 0: separate write then read, then same-cycle.
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_0042);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
      check("t4_nz_a", a_n, 32'h0000_0042);
      drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_0042);
      check("t4_z_a", a_z, 32'h0);
      check("t4_z_ah", W'(ah_z), 32'h0);

      // Hold: later write does not disturb the latched operand.
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h11);
      drive(1'b1, 5'd9, 5'd3, 1'b0, 5'd0, 32'h0);
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h22);
      check("t5_hold", a_z, 32'h11);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0);
      check("t5_new", a_z, 32'h22);

      // Sweep every address, back-to-back reads.
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101);
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
      end

      // Randomized traffic, biased toward read/write address collisions.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] w_a, r1, r2;
         w_a = 5'($urandom_range(0, 31));
         r1  = ($urandom_range(0, 3) == 0) ? w_a : 5'($urandom_range(0, 31));
         r2  = ($urandom_range(0, 3) == 0) ? w_a : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), r1, r2, 1'($urandom_range(0, 1)), w_a, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
